pool2x2_stream_ctrl: RTL

Streaming 2x2 stride-2 pooling controller for the CNN accelerator pooling stage.
- Accepts one feature-map channel as a raster-ordered pixel stream (valid/ready).
- Sequences two pair-reduction units, horizontal then vertical, with a half-row line buffer.
- Emits one pooled pixel per 2x2 window, in raster order, on a valid/ready output stream.
- Sits between the convolution/activation output and the next layer's input buffer. Software starts one frame per start pulse.

---
 rtl/pool2x2_stream_ctrl_pkg.sv | 15 +
 rtl/pool2x2_stream_ctrl_pair_reduce.sv | 23 ++
 rtl/pool2x2_stream_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pool2x2_stream_ctrl_pkg.sv
// Shared types and defaults for the 2x2 stride-2 pooling stage.
package pool_pkg;
   localparam int DEFAULT_DATA_WIDTH = 16;

   typedef enum logic {
      POOL_AVG = 1'b0,
      POOL_MAX = 1'b1
   } pool_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pool_state_e;
endpackage

// File: rtl/pool2x2_stream_ctrl_pair_reduce.sv
// Combinational two-operand reduction: unsigned max, or truncating average.
module pool_pair_reduce
   import pool_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  pool_mode_e            mode,
   output logic [DATA_WIDTH-1:0] y
);
   logic [DATA_WIDTH:0] sum;

   always_comb begin
      // One extra bit keeps the carry, so averaging full-scale values cannot wrap.
      sum = {1'b0, a} + {1'b0, b};
      if (mode == POOL_MAX) begin
         y = (a > b) ? a : b;
      end else begin
         y = sum[DATA_WIDTH:1];
      end
   end
endmodule

// File: rtl/pool2x2_stream_ctrl.sv
// Streaming 2x2 stride-2 pooling controller: horizontal pair, half-row line buffer, vertical pair.
module pool2x2_stream_ctrl
   import pool_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int MAX_COLS   = 64,
   parameter int MAX_ROWS   = 64,
   parameter int COL_W      = $clog2(MAX_COLS + 1),
   parameter int ROW_W      = $clog2(MAX_ROWS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COL_W-1:0]      cfg_cols,
   input  logic [ROW_W-1:0]      cfg_rows,
   input  logic                  cfg_mode,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);
   localparam int LB_DEPTH = MAX_COLS / 2;
   localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   pool_state_e           state_q;
   pool_mode_e            mode_q;
   logic [COL_W-1:0]      cols_q, col_q, col_d;
   logic [ROW_W-1:0]      rows_q, row_q, row_d;
   logic [DATA_WIDTH-1:0] pend_q;
   logic                  pend_vld_q;
   logic                  in_done_q;
   logic                  busy_q, done_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_valid_q, out_valid_d;

   logic [DATA_WIDTH-1:0] line_buf [LB_DEPTH];

   logic [COL_W-1:0]      cols_eff;
   logic [ROW_W-1:0]      rows_eff;
   logic                  cfg_bad;
   logic                  in_ready_c, in_hs;
   logic                  last_col, last_row;
   logic                  load, lb_wr;
   logic [LB_AW-1:0]      lb_idx;
   logic [DATA_WIDTH-1:0] lb_rd, h_y, v_y;

   assign cols_eff = cfg_cols & ~COL_W'(1);
   assign rows_eff = cfg_rows & ~ROW_W'(1);
   assign cfg_bad  = (cols_eff == '0) || (rows_eff == '0) ||
                     (cols_eff > COL_W'(MAX_COLS)) || (rows_eff > ROW_W'(MAX_ROWS));

   assign in_ready_c = (state_q == RUN) && !(out_valid_q && !out_ready) && !in_done_q;
   assign in_hs      = in_valid && in_ready_c;
   assign last_col   = (col_q == cols_q - COL_W'(1));
   assign last_row   = (row_q == rows_q - ROW_W'(1));
   assign lb_idx     = col_q[LB_AW:1];
   assign lb_rd      = line_buf[lb_idx];
   assign lb_wr      = in_hs && col_q[0] && !row_q[0] && pend_vld_q;
   assign load       = in_hs && col_q[0] && row_q[0] && pend_vld_q;

   pool_pair_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_h_reduce (
      .a    (pend_q),
      .b    (in_data),
      .mode (mode_q),
      .y    (h_y)
   );

   pool_pair_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_v_reduce (
      .a    (lb_rd),
      .b    (h_y),
      .mode (mode_q),
      .y    (v_y)
   );

   always_comb begin
      col_d = last_col ? '0 : col_q + COL_W'(1);
      row_d = last_col ? row_q + ROW_W'(1) : row_q;
      // A load wins over a same-cycle handshake so back-to-back results never drop.
      if (load) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= POOL_AVG;
         cols_q      <= '0;
         rows_q      <= '0;
         col_q       <= '0;
         row_q       <= '0;
         pend_q      <= '0;
         pend_vld_q  <= 1'b0;
         in_done_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         out_valid_q <= out_valid_d;
         if (load) begin
            out_data_q <= v_y;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  cols_q     <= cols_eff;
                  rows_q     <= rows_eff;
                  mode_q     <= pool_mode_e'(cfg_mode);
                  col_q      <= '0;
                  row_q      <= '0;
                  pend_vld_q <= 1'b0;
                  in_done_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  if (cfg_bad) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (in_hs) begin
                  col_q <= col_d;
                  row_q <= row_d;
                  if (!col_q[0]) begin
                     pend_q     <= in_data;
                     pend_vld_q <= 1'b1;
                  end else begin
                     pend_vld_q <= 1'b0;
                  end
                  if (last_col && last_row) begin
                     in_done_q <= 1'b1;
                  end
               end
               // The final input always yields the final output, so its handshake ends the frame.
               if (in_done_q && out_valid_q && out_ready) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (lb_wr) begin
         line_buf[lb_idx] <= h_y;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign in_ready  = in_ready_c;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
endmodule
